// File: rtl/bpi_pkg.sv
// bpi_pkg: BPI read scheduler state encoding, owner codes and defaults.
// Shared by bpi_word_rd and bpi_rd_sched.
package bpi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SETUP,
    WAIT,
    CAPT,
    NEXT,
    HOLD
  } state_t;

  localparam logic OWN_SCAN = 1'b0;
  localparam logic OWN_PAGE = 1'b1;

  localparam int PAGE_WORDS_DEF = 128;
  localparam int RD_WAIT_DEF    = 4;

endpackage

// File: rtl/bpi_word_rd.sv
// bpi_word_rd: one flash word read, SETUP -> WAIT x RD_WAIT -> CAPT.
// A start seen in CAPT chains straight into the next SETUP.
module bpi_word_rd
  import bpi_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] flash_dq,
  output logic        done,
  output logic        ce_n,
  output logic        oe_n,
  output logic [15:0] data,
  output logic        data_en
);

  localparam int CW = $clog2(RD_WAIT + 1);

  state_t        st;
  state_t        nx;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(RD_WAIT - 1));
  assign ce_n = !((st == SETUP) || (st == WAIT) || (st == CAPT));
  assign oe_n = ce_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      cnt     <= '0;
      data    <= '0;
      data_en <= 1'b0;
    end else begin
      st      <= nx;
      cnt     <= (st == WAIT && !last) ? cnt + CW'(1) : '0;
      // sample on the last WAIT edge so the word is valid during CAPT
      data_en <= (st == WAIT) && last;
      if (st == WAIT && last) data <= flash_dq;
    end
  end

  always_comb begin
    nx   = st;
    done = 1'b0;
    unique case (st)
      IDLE:  if (start) nx = SETUP;
      SETUP: nx = WAIT;
      WAIT:  if (last) nx = CAPT;
      CAPT: begin
        done = 1'b1;
        nx   = start ? SETUP : IDLE;
      end
      default: nx = IDLE;
    endcase
  end

endmodule

// File: rtl/bpi_rd_sched.sv
// bpi_rd_sched: round-robin scan/page arbiter for a BPI flash read port.
// Define BPI_RD_TIMEOUT_EN to abort a scan stalled on rd_ready.
module bpi_rd_sched
  import bpi_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int PAGE_WORDS = PAGE_WORDS_DEF,
  parameter int RD_WAIT    = RD_WAIT_DEF,
  parameter logic [ADDR_W-1:0] SCAN_BASE  = 24'h0,
  parameter logic [ADDR_W-1:0] SCAN_LIMIT = 24'h10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_start,
  input  logic              scan_stop,
  input  logic              page_req,
  input  logic [ADDR_W-1:0] page_addr,
  output logic              page_gnt,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  input  logic [15:0]       flash_dq,
  output logic [15:0]       rd_data,
  output logic              rd_data_en,
  output logic              rd_owner,
  output logic              bpi_idle,
  output logic              scan_busy,
  output logic              scan_err
);

  localparam int WW = $clog2(PAGE_WORDS + 1);
  localparam int PW = ADDR_W + 1;

  state_t          state;
  state_t          nx;
  logic [WW-1:0]   wcnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] ptr_nx;
  logic            own;
  logic            busy;
  logic            err;
  logic            start;
  logic            done;
  logic            scan_req;
  logic            pick_page;
  logic            pick_scan;
  logic            last_word;

  // last owner loses a tie
  assign scan_req  = busy & rd_ready & ~scan_stop;
  assign pick_page = page_req & (~scan_req | (own == OWN_SCAN));
  assign pick_scan = scan_req & ~pick_page;
  assign last_word = (wcnt == WW'(PAGE_WORDS - 1));
  assign ptr_nx    = {1'b0, ptr} + PW'(PAGE_WORDS);

  assign flash_addr = addr;
  assign rd_owner   = own;
  assign bpi_idle   = (state == IDLE);
  assign scan_busy  = busy;
  assign scan_err   = err;

  bpi_word_rd #(
    .RD_WAIT(RD_WAIT)
  ) u_word (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flash_dq(flash_dq),
    .done    (done),
    .ce_n    (flash_ce_n),
    .oe_n    (flash_oe_n),
    .data    (rd_data),
    .data_en (rd_data_en)
  );

  always_comb begin
    nx       = state;
    start    = 1'b0;
    page_gnt = 1'b0;
    unique case (state)
      IDLE: if ((busy & rd_ready) | page_req) nx = ARB;
      ARB: begin
        unique case (1'b1)
          pick_page: begin
            page_gnt = 1'b1;
            start    = 1'b1;
            nx       = WAIT;
          end
          pick_scan: begin
            start = 1'b1;
            nx    = WAIT;
          end
          default: nx = IDLE;
        endcase
      end
      WAIT: begin
        if (done && last_word) nx = HOLD;
        else if (done) begin
          start = 1'b1;
          nx    = NEXT;
        end
      end
      NEXT:    nx = WAIT;
      HOLD:    nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      wcnt  <= '0;
      own   <= OWN_SCAN;
    end else begin
      state <= nx;
      if (state == ARB) begin
        wcnt <= '0;
        if (pick_page) begin
          addr <= page_addr;
          own  <= OWN_PAGE;
        end else if (pick_scan) begin
          addr <= ptr;
          own  <= OWN_SCAN;
        end
      end
      if (state == WAIT && done && !last_word) begin
        addr <= addr + 1'b1;
        wcnt <= wcnt + WW'(1);
      end
    end
  end

`ifdef BPI_RD_TIMEOUT_EN
  logic [15:0] tmo;
  logic        stall;

  assign stall = busy & ~rd_ready & (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo <= '0;
    else if (stall && tmo != 16'hFFFE) tmo <= tmo + 16'd1;
    else tmo <= '0;
  end
`endif

  // ptr_nx carries one extra bit so the limit test never sees a wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      ptr  <= '0;
      err  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (scan_stop) begin
        busy <= 1'b0;
      end else if (scan_start && !busy && state == IDLE) begin
        busy <= 1'b1;
        ptr  <= SCAN_BASE;
      end else if (state == HOLD && own == OWN_SCAN && busy) begin
        if (ptr_nx >= {1'b0, SCAN_LIMIT}) begin
          err  <= 1'b1;
          busy <= 1'b0;
        end else begin
          ptr <= ptr_nx[ADDR_W-1:0];
        end
      end
`ifdef BPI_RD_TIMEOUT_EN
      else if (stall && tmo == 16'hFFFE) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bpi_rd_sched.sv
// tb_bpi_rd_sched: directed checks of bpi_rd_sched, PAGE_WORDS=4, RD_WAIT=4.
// u_lim shares the stimulus but runs with SCAN_LIMIT=8.
module tb_bpi_rd_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_start = 1'b0;
  logic        scan_stop = 1'b0;
  logic        page_req = 1'b0;
  logic [23:0] page_addr = '0;
  logic        rd_ready = 1'b0;

  logic        d_gnt, d_ce_n, d_oe_n, d_en, d_own, d_idle, d_busy, d_err;
  logic [23:0] d_addr;
  logic [15:0] d_dq, d_data;
  logic        l_gnt, l_ce_n, l_oe_n, l_en, l_own, l_idle, l_busy, l_err;
  logic [23:0] l_addr;
  logic [15:0] l_dq, l_data;

  assign d_dq = {8'hA5, d_addr[7:0]};
  assign l_dq = {8'h5A, l_addr[7:0]};

  always #5 clk = ~clk;

  bpi_rd_sched #(
    .PAGE_WORDS(4), .RD_WAIT(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .scan_start(scan_start),
    .scan_stop(scan_stop), .page_req(page_req),
    .page_addr(page_addr), .page_gnt(d_gnt),
    .rd_ready(rd_ready), .flash_addr(d_addr),
    .flash_ce_n(d_ce_n), .flash_oe_n(d_oe_n),
    .flash_dq(d_dq), .rd_data(d_data), .rd_data_en(d_en),
    .rd_owner(d_own), .bpi_idle(d_idle),
    .scan_busy(d_busy), .scan_err(d_err)
  );

  bpi_rd_sched #(
    .PAGE_WORDS(4), .RD_WAIT(4), .SCAN_LIMIT(24'h8)
  ) u_lim (
    .clk(clk), .rst_n(rst_n), .scan_start(scan_start),
    .scan_stop(scan_stop), .page_req(page_req),
    .page_addr(page_addr), .page_gnt(l_gnt),
    .rd_ready(rd_ready), .flash_addr(l_addr),
    .flash_ce_n(l_ce_n), .flash_oe_n(l_oe_n),
    .flash_dq(l_dq), .rd_data(l_data), .rd_data_en(l_en),
    .rd_owner(l_own), .bpi_idle(l_idle),
    .scan_busy(l_busy), .scan_err(l_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int          q_cyc[$];
  logic [23:0] q_addr[$];
  logic [15:0] q_data[$];
  logic        q_own[$];
  int          q_gnt[$];
  int          d_ce_cnt, d_err_n, l_en_n, l_err_n;
  logic [23:0] d_max, l_max;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d_en) begin
      q_cyc.push_back(cyc);
      q_addr.push_back(d_addr);
      q_data.push_back(d_data);
      q_own.push_back(d_own);
    end
    if (d_gnt) q_gnt.push_back(cyc);
    if (!d_ce_n) begin
      d_ce_cnt++;
      if (d_addr > d_max) d_max = d_addr;
    end
    if (d_err) d_err_n++;
    if (l_en) l_en_n++;
    if (l_err) l_err_n++;
    if (!l_ce_n && l_addr > l_max) l_max = l_addr;
  end

  task automatic clear_mon();
    q_cyc.delete(); q_addr.delete();
    q_data.delete(); q_own.delete(); q_gnt.delete();
    d_ce_cnt = 0; d_err_n = 0; l_en_n = 0; l_err_n = 0;
    d_max = '0; l_max = '0;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; scan_start = 1'b0; scan_stop = 1'b0;
    page_req = 1'b0; page_addr = '0; rd_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic pulse_start();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    @(negedge clk);
    n_cmp++;
    if ({d_ce_n, d_oe_n, d_en, d_gnt, d_busy, d_err, d_idle}
        !== 7'b1100001) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 1100001",
        {d_ce_n, d_oe_n, d_en, d_gnt, d_busy, d_err, d_idle});
    end
    n_cmp++;
    if (d_addr !== 24'h0) begin
      n_bad++; $display("FAIL reset_addr got %h want 0", d_addr);
    end
    n_cmp++;
    if (d_data !== 16'h0) begin
      n_bad++; $display("FAIL reset_data got %h want 0", d_data);
    end
  endtask

  task automatic test_scan_page();
    int t0;
    do_reset();
    rd_ready = 1'b1;
    t0 = cyc;
    pulse_start();
    tick(3);
    rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({d_idle, d_ce_n, d_oe_n} !== 3'b000 || d_addr !== 24'h0) begin
      n_bad++;
      $display("FAIL scan_mid got idle/ce/oe %b addr %h want 000 0",
        {d_idle, d_ce_n, d_oe_n}, d_addr);
    end
    tick(40);
    n_cmp++;
    if (q_cyc.size() != 4) begin
      n_bad++;
      $display("FAIL scan_words got %0d want 4", q_cyc.size());
    end
    for (int i = 0; i < q_cyc.size() && i < 4; i++) begin
      n_cmp++;
      if (q_cyc[i] != t0 + 8 + 6 * i || q_addr[i] !== 24'(i) ||
          q_own[i] !== 1'b0 || q_data[i] !== 16'hA500 + 16'(i)) begin
        n_bad++;
        $display("FAIL scan_word%0d got t%0d a%h o%b d%h want t%0d a%h o0 d%h",
          i, q_cyc[i] - t0, q_addr[i], q_own[i], q_data[i],
          8 + 6 * i, i, 16'hA500 + 16'(i));
      end
    end
    n_cmp++;
    if ({d_idle, d_ce_n, d_busy} !== 3'b111) begin
      n_bad++;
      $display("FAIL scan_end got idle/ce/busy %b want 111",
        {d_idle, d_ce_n, d_busy});
    end
  endtask

  task automatic test_page_preempt();
    logic got = 1'b0;
    clear_mon();
    rd_ready = 1'b1;
    tick(5);
    page_req = 1'b1;
    page_addr = 24'h100;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = d_gnt;
      tick();
    end
    page_req = 1'b0;
    rd_ready = 1'b0;
    page_addr = 24'h0;
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL page_gnt got none want 1 pulse");
    end
    tick(40);
    n_cmp++;
    if (q_cyc.size() != 8 || q_gnt.size() != 1) begin
      n_bad++;
      $display("FAIL page_counts got words %0d gnts %0d want 8 1",
        q_cyc.size(), q_gnt.size());
    end else begin
      n_cmp++;
      if (q_gnt[0] != q_cyc[3] + 3) begin
        n_bad++;
        $display("FAIL page_gnt_time got %0d want %0d",
          q_gnt[0], q_cyc[3] + 3);
      end
      for (int i = 0; i < 8; i++) begin
        logic [23:0] ea;
        ea = (i < 4) ? 24'(4 + i) : 24'(24'h100 + i - 4);
        n_cmp++;
        if (q_addr[i] !== ea || q_own[i] !== (i >= 4) ||
            q_data[i] !== {8'hA5, ea[7:0]}) begin
          n_bad++;
          $display("FAIL page_word%0d got a%h o%b d%h want a%h o%b",
            i, q_addr[i], q_own[i], q_data[i], ea, i >= 4);
        end
      end
    end
  endtask

  task automatic test_scan_stop();
    logic fire;
    logic stopped = 1'b0;
    do_reset();
    rd_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      fire = !stopped && d_addr == 24'd9 && !d_ce_n;
      tick();
      scan_stop = fire;
      if (fire) stopped = 1'b1;
    end
    scan_stop = 1'b0;
    n_cmp++;
    if (q_addr.size() != 12 || d_max !== 24'd11) begin
      n_bad++;
      $display("FAIL stop_words got %0d max %h want 12 b",
        q_addr.size(), d_max);
    end
    n_cmp++;
    if ({d_busy, d_idle, d_ce_n} !== 3'b011 || d_err_n != 0) begin
      n_bad++;
      $display("FAIL stop_end got busy/idle/ce %b err %0d want 011 0",
        {d_busy, d_idle, d_ce_n}, d_err_n);
    end
  endtask

  task automatic test_scan_limit();
    do_reset();
    rd_ready = 1'b1;
    pulse_start();
    tick(100);
    n_cmp++;
    if (l_en_n != 8 || l_max !== 24'd7) begin
      n_bad++;
      $display("FAIL limit_words got %0d max %h want 8 7", l_en_n, l_max);
    end
    n_cmp++;
    if (l_err_n != 1 || l_busy !== 1'b0 || l_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL limit_err got err %0d busy %b idle %b want 1 0 1",
        l_err_n, l_busy, l_idle);
    end
  endtask

  task automatic test_start_rules();
    do_reset();
    scan_start = 1'b1;
    scan_stop = 1'b1;
    tick();
    scan_start = 1'b0;
    scan_stop = 1'b0;
    rd_ready = 1'b1;
    tick(10);
    n_cmp++;
    if (d_busy !== 1'b0 || q_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL tie_stop got busy %b words %0d want 0 0",
        d_busy, q_cyc.size());
    end
    pulse_start();
    tick(3);
    rd_ready = 1'b0;
    tick(30);
    pulse_start();
    clear_mon();
    rd_ready = 1'b1;
    tick(2);
    rd_ready = 1'b0;
    tick(30);
    n_cmp++;
    if (q_cyc.size() != 4 || q_addr[0] !== 24'd4) begin
      n_bad++;
      $display("FAIL start_busy got words %0d first %h want 4 4",
        q_cyc.size(), q_addr[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    do_reset();
    rd_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = d_addr == 24'd2 && !d_ce_n;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!found || {d_ce_n, d_oe_n, d_en, d_busy, d_idle} !== 5'b11001 ||
        d_addr !== 24'h0 || d_data !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_mid got ctl %b addr %h data %h want 11001 0 0",
        {d_ce_n, d_oe_n, d_en, d_busy, d_idle}, d_addr, d_data);
    end
    clear_mon();
    tick(3);
    rst_n = 1'b1;
    tick(30);
    n_cmp++;
    if (q_cyc.size() != 0 || d_ce_cnt != 0) begin
      n_bad++;
      $display("FAIL reset_quiet got strobes %0d ce %0d want 0 0",
        q_cyc.size(), d_ce_cnt);
    end
  endtask

`ifdef BPI_RD_TIMEOUT_EN
  task automatic test_timeout();
    int n0 = -1;
    int n1 = -1;
    do_reset();
    rd_ready = 1'b1;
    pulse_start();
    tick(3);
    rd_ready = 1'b0;
    for (int i = 0; i < 100 && n0 < 0; i++) begin
      @(negedge clk);
      if (d_idle) n0 = cyc;
    end
    for (int i = 0; i < 70000 && n1 < 0; i++) begin
      @(negedge clk);
      if (d_err) n1 = cyc;
    end
    n_cmp++;
    if (n0 < 0 || n1 < 0 || n1 - n0 != 65535 || d_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout got %0d busy %b want 65535 0",
        n1 - n0, d_busy);
    end
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_scan_page();
    test_page_preempt();
    test_scan_stop();
    test_scan_limit();
    test_start_rules();
    test_reset_mid();
`ifdef BPI_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bpi_rd_sched.md
BPI_RD_SCHED -- requirements
Module: bpi_rd_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 24, flash word-address width.
- PAGE_WORDS, 128, 16-bit words per page (one 256-byte record).
- RD_WAIT, 4, clk cycles from flash_oe_n low to data sample, minimum 1.
- SCAN_BASE, 24'h0, first word address of the reconfig record area.
- SCAN_LIMIT, 24'h10000, scan address ceiling (exclusive).
REQ-002 The block SHALL have these ports (name, direction, width, meaning). One clock; reset is asynchronous and active-low.
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- scan_start, in, 1, pulse: begin record scan at SCAN_BASE.
- scan_stop, in, 1, pulse: record end found, terminate scan.
- page_req, in, 1, level: single-page read request, held until page_gnt.
- page_addr, in, ADDR_W, page start address, sampled on grant.
- page_gnt, out, 1, one-cycle grant pulse for page_req.
- rd_ready, in, 1, downstream buffer can absorb one full page.
- flash_addr, out, ADDR_W, flash word address.
- flash_ce_n, out, 1, flash chip enable.
- flash_oe_n, out, 1, flash output enable.
- flash_dq, in, 16, flash read data.
- rd_data, out, 16, captured word.
- rd_data_en, out, 1, rd_data valid strobe.
- rd_owner, out, 1, 0 = scan, 1 = page request; valid with rd_data_en.
- bpi_idle, out, 1, high when no page transfer is in progress.
- scan_busy, out, 1, scan session active.
- scan_err, out, 1, one-cycle pulse: limit reached or timeout.

Function
REQ-003 FSM states SHALL be: IDLE, ARB, SETUP, WAIT, CAPT, NEXT, HOLD.
REQ-004 Transition IDLE->ARB SHALL occur when (scan_busy and rd_ready) or page_req is high.
- ARB SHALL grant round-robin at page boundaries only.
- The last owner SHALL lose a tie.
REQ-005 A page_req grant SHALL pulse page_gnt in the ARB cycle and latch page_addr.
REQ-006 SETUP SHALL drive flash_addr and assert flash_ce_n=0 and flash_oe_n=0. WAIT SHALL last exactly RD_WAIT cycles.
REQ-007 CAPT SHALL register flash_dq onto rd_data with rd_data_en=1 for one cycle.
- Latency: the SETUP cycle plus RD_WAIT+1 cycles per word.
REQ-008 NEXT SHALL increment the address by 1 and return to SETUP until PAGE_WORDS words are read, then go to HOLD.
REQ-009 HOLD SHALL deassert ce/oe for 1 cycle, then go to IDLE.
REQ-010 bpi_idle SHALL be 0 from ARB through HOLD, and 1 otherwise.
REQ-011 On scan_start while idle: set scan_busy and load the scan pointer to SCAN_BASE. scan_start SHALL be ignored while scan_busy=1.
REQ-012 After each completed scan page, the scan pointer SHALL advance by PAGE_WORDS. The next scan page SHALL wait for rd_ready=1.
REQ-013 scan_stop SHALL clear scan_busy.
- A page in flight SHALL complete.
- No further scan page SHALL be issued.
- scan_stop SHALL have no effect when scan_busy=0.
REQ-014 If the scan pointer reaches or exceeds SCAN_LIMIT, the block SHALL pulse scan_err and clear scan_busy. The address SHALL never wrap.
REQ-015 When scan_start and scan_stop occur in the same cycle, scan_stop SHALL win.
REQ-016 A page_req arriving mid-page SHALL wait. It SHALL be granted at the next ARB ahead of a pending scan page if scan owned the last page.

Reset
REQ-017 While rst_n=0, the block SHALL force:
- state = IDLE.
- flash_ce_n = 1, flash_oe_n = 1.
- flash_addr, rd_data and the scan pointer = 0.
- rd_data_en, page_gnt, scan_busy and scan_err = 0.
- bpi_idle = 1.
REQ-018 Reset asserted mid-page SHALL abandon the page immediately and issue no further strobes.

Configuration
REQ-019 With BPI_RD_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles in which scan_busy=1, rd_ready=0 and state=IDLE.
- At 65535 the block SHALL pulse scan_err and clear scan_busy.
- Without the macro there SHALL be no timeout, and scan waits indefinitely.

Structure
REQ-020 A shared package bpi_pkg SHALL hold:
- the FSM state encoding;
- the owner constants (OWN_SCAN=0, OWN_PAGE=1);
- the defaults for PAGE_WORDS and RD_WAIT.
REQ-021 The word timing SETUP/WAIT/CAPT SHALL be one sub-module, bpi_word_rd, with a start/done handshake. Arbitration and scan sequencing stay in bpi_rd_sched.

Verification
REQ-022 Bench scenarios (stimulus -> required response), using RD_WAIT=4 and PAGE_WORDS=4:
- Reset, then scan_start with rd_ready=1 -> flash_addr 0,1,2,3; 4 rd_data_en pulses spaced 6 cycles apart; rd_owner=0; bpi_idle returns to 1.
- page_req with page_addr=0x100 during a scan page -> page_gnt after scan page completes; addresses 0x100..0x103; rd_owner=1.
- scan_stop on the 2nd word of page 3 -> page 3 finishes; scan_busy=0; no page 4.
- SCAN_LIMIT=8, scan never stopped -> 2 pages read; scan_err pulses once; scan_busy=0.
- rst_n low on word 2 -> flash_ce_n=1 immediately; outputs at reset values.
- BPI_RD_TIMEOUT_EN defined, rd_ready held 0 -> scan_err 65535 cycles after page 1 ends.
